// File: rtl/ahb_dec_mux.sv
// AHB address decoder and data-phase read mux with a built-in default slave.
// The address-phase hsel is decoded from haddr[31:24]; the data-phase select is
// registered whenever hready is high.
module ahb_dec_mux #(
    parameter int                NSLV     = 2,
    parameter int                DW       = 32,
    parameter logic [8*NSLV-1:0] SLV_BASE = {8'hB0, 8'hA0}
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [31:0]                haddr,
    input  logic [1:0]                 htrans,
    output logic [NSLV-1:0]            hsel,
    input  logic [NSLV*DW-1:0]         hrdata_s,
    input  logic [NSLV-1:0]            hreadyout_s,
    input  logic [NSLV-1:0]            hresp_s,
    output logic [DW-1:0]              hrdata,
    output logic                       hready,
    output logic                       hresp,
    output logic [$clog2(NSLV+1)-1:0]  dsel
);

    localparam int SW = $clog2(NSLV + 1);

    typedef enum logic [1:0] {
        DS_IDLE = 2'd0,
        DS_ERR1 = 2'd1,
        DS_ERR2 = 2'd2
    } ds_state_t;

    logic [NSLV-1:0] match;
    logic [NSLV-1:0] hsel_c;
    logic [SW-1:0]   dec_idx;
    logic            unmapped;
    logic            active_err;
    logic [SW-1:0]   dsel_reg;
    ds_state_t       state_reg;
    ds_state_t       state_next;
    logic            ds_ready;
    logic            ds_resp;
    logic            unused_bits;

    // Only the region tag and the NONSEQ/SEQ bit take part in decoding.
    assign unused_bits = ^{haddr[23:0], htrans[0]};

    genvar gi;
    generate
        for (gi = 0; gi < NSLV; gi++) begin : g_match
            assign match[gi] = (haddr[31:24] == SLV_BASE[8*gi +: 8]);
        end
    endgenerate

    // Descending scan so that the lowest matching index is the one that sticks.
    always_comb begin
        hsel_c  = '0;
        dec_idx = SW'(NSLV);
        for (int i = NSLV - 1; i >= 0; i--) begin
            if (match[i]) begin
                hsel_c    = '0;
                hsel_c[i] = 1'b1;
                dec_idx   = SW'(i);
            end
        end
    end

    assign hsel       = hsel_c;
    assign unmapped   = ~|match;
    assign active_err = hready & unmapped & htrans[1];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= DS_IDLE;
            dsel_reg  <= SW'(NSLV);
        end else begin
            state_reg <= state_next;
            if (hready) begin
                dsel_reg <= dec_idx;
            end
        end
    end

    // Default slave: two-cycle ERROR response to active unmapped transfers.
    always_comb begin
        state_next = state_reg;
        ds_ready   = 1'b1;
        ds_resp    = 1'b0;
        case (state_reg)
            DS_IDLE: begin
                if (active_err) state_next = DS_ERR1;
            end
            DS_ERR1: begin
                ds_ready   = 1'b0;
                ds_resp    = 1'b1;
                state_next = DS_ERR2;
            end
            DS_ERR2: begin
                ds_resp    = 1'b1;
                state_next = active_err ? DS_ERR1 : DS_IDLE;
            end
            default: state_next = DS_IDLE;
        endcase
    end

    always_comb begin
        hrdata = '0;
        hready = ds_ready;
        hresp  = ds_resp;
        for (int i = 0; i < NSLV; i++) begin
            if (dsel_reg == SW'(i)) begin
                hrdata = hrdata_s[DW*i +: DW];
                hready = hreadyout_s[i];
                hresp  = hresp_s[i];
            end
        end
    end

    assign dsel = dsel_reg;

endmodule

// File: tb/tb_ahb_dec_mux.sv
// Randomized scoreboard bench for ahb_dec_mux (three slaves, tags A0/B0/A0 so
// the lowest-index priority rule is exercised), plus directed reset scenarios.
module tb_ahb_dec_mux;

    localparam int NSLV = 3;
    localparam int DW   = 32;
    localparam int SW   = 2;
    localparam int NCYC = 400;

    logic                 clk;
    logic                 reset_n;
    logic [31:0]          haddr;
    logic [1:0]           htrans;
    logic [NSLV-1:0]      hsel;
    logic [NSLV*DW-1:0]   hrdata_s;
    logic [NSLV-1:0]      hreadyout_s;
    logic [NSLV-1:0]      hresp_s;
    logic [DW-1:0]        hrdata;
    logic                 hready;
    logic                 hresp;
    logic [SW-1:0]        dsel;

    ahb_dec_mux #(
        .NSLV    (NSLV),
        .DW      (DW),
        .SLV_BASE(24'hA0_B0_A0)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .haddr      (haddr),
        .htrans     (htrans),
        .hsel       (hsel),
        .hrdata_s   (hrdata_s),
        .hreadyout_s(hreadyout_s),
        .hresp_s    (hresp_s),
        .hrdata     (hrdata),
        .hready     (hready),
        .hresp      (hresp),
        .dsel       (dsel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected data-phase response of one transfer: w wait cycles carrying
    // wresp, then a ready cycle with data d and response r.
    typedef struct {
        int              idx;
        int              w;
        logic            wresp;
        logic [DW-1:0]   d;
        logic            r;
    } exp_t;

    exp_t       exp_q[$];
    exp_t       a_exp;
    exp_t       cur;
    int         cur_wait;
    logic       hr_s;
    logic       mon_en;
    int         n_pass;
    int         n_total;
    logic [7:0] tags [NSLV];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, req, $time);
    endtask

    function automatic int model_idx(input logic [31:0] a);
        for (int i = 0; i < NSLV; i++)
            if (a[31:24] == tags[i]) return i;
        return NSLV;
    endfunction

    function automatic logic [NSLV-1:0] model_hsel(input logic [31:0] a);
        logic [NSLV-1:0] s;
        int k;
        s = '0;
        k = model_idx(a);
        if (k < NSLV) s[k] = 1'b1;
        return s;
    endfunction

    task automatic new_addr();
        int sel;
        logic [7:0] tag;
        sel = $urandom_range(0, 3);
        case (sel)
            0:       tag = 8'hA0;
            1:       tag = 8'hB0;
            2:       tag = 8'hC0;
            default: tag = 8'($urandom);
        endcase
        haddr  = {tag, 24'($urandom)};
        htrans = 2'($urandom);
        a_exp.idx = model_idx(haddr);
        if (a_exp.idx < NSLV) begin
            a_exp.w     = htrans[1] ? $urandom_range(0, 3) : 0;
            a_exp.wresp = 1'b0;
            a_exp.d     = $urandom;
            a_exp.r     = htrans[1] ? ($urandom_range(0, 3) == 0) : 1'b0;
        end else if (htrans[1]) begin
            a_exp.w     = 1;
            a_exp.wresp = 1'b1;
            a_exp.d     = '0;
            a_exp.r     = 1'b1;
        end else begin
            a_exp.w     = 0;
            a_exp.wresp = 1'b0;
            a_exp.d     = '0;
            a_exp.r     = 1'b0;
        end
    endtask

    // Unselected slaves babble random values; the slave owning the current
    // data phase inserts its wait states and then returns its data.
    task automatic drive_slaves();
        for (int i = 0; i < NSLV; i++) begin
            hrdata_s[DW*i +: DW] = $urandom;
            hreadyout_s[i]       = 1'($urandom);
            hresp_s[i]           = 1'($urandom);
        end
        if (cur.idx < NSLV) begin
            hreadyout_s[cur.idx] = (cur_wait == 0);
            hresp_s[cur.idx]     = (cur_wait == 0) ? cur.r : 1'b0;
            if (cur_wait == 0) hrdata_s[DW*cur.idx +: DW] = cur.d;
        end
    endtask

    // Monitor: consumes one expected entry per completed data phase.
    initial begin
        int cnt;
        int ntx;
        exp_t e;
        cnt = 0;
        ntx = 0;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                chk("hsel", 64'(hsel), 64'(model_hsel(haddr)));
                if (exp_q.size() == 0) begin
                    n_total++;
                    $display("FAIL scoreboard: got data phase with hready=%0b, required a pending transfer", hready);
                end else begin
                    e = exp_q[0];
                    chk("dsel", 64'(dsel), 64'(e.idx));
                    if (cnt < e.w) begin
                        chk("wait_hready", 64'(hready), 64'(0));
                        chk("wait_hresp", 64'(hresp), 64'(e.wresp));
                    end else begin
                        chk("hready", 64'(hready), 64'(1));
                        chk("hresp", 64'(hresp), 64'(e.r));
                        chk("hrdata", 64'(hrdata), 64'(e.d));
                    end
                    if (hready) begin
                        $display("txn %0d dsel=%0d waits=%0d hrdata=%h hresp=%0b",
                                 ntx, dsel, cnt, hrdata, hresp);
                        void'(exp_q.pop_front());
                        ntx++;
                        cnt = 0;
                    end else begin
                        cnt++;
                    end
                end
            end
        end
    end

    initial begin
        tags[0] = 8'hA0;
        tags[1] = 8'hB0;
        tags[2] = 8'hA0;
        n_pass      = 0;
        n_total     = 0;
        mon_en      = 1'b0;
        reset_n     = 1'b0;
        haddr       = '0;
        htrans      = 2'b00;
        hrdata_s    = '0;
        hreadyout_s = '0;
        hresp_s     = '0;
        cur = '{idx: NSLV, w: 0, wresp: 1'b0, d: '0, r: 1'b0};
        cur_wait = 0;
        new_addr();
        drive_slaves();

        repeat (2) @(posedge clk);
        #1;
        chk("rst_hready", 64'(hready), 64'(1));
        chk("rst_hresp", 64'(hresp), 64'(0));
        chk("rst_hrdata", 64'(hrdata), 64'(0));
        chk("rst_dsel", 64'(dsel), 64'(NSLV));
        chk("rst_hsel", 64'(hsel), 64'(model_hsel(haddr)));

        exp_q.push_back(cur);
        reset_n = 1'b1;
        mon_en  = 1'b1;

        for (int c = 0; c < NCYC; c++) begin
            @(negedge clk);
            hr_s = hready;
            @(posedge clk);
            #1;
            if (hr_s) begin
                cur      = a_exp;
                cur_wait = cur.w;
                exp_q.push_back(cur);
                new_addr();
            end else if (cur_wait > 0) begin
                cur_wait--;
            end
            drive_slaves();
        end
        mon_en = 1'b0;

        // Unmapped IDLE transfers get zero-wait OKAY.
        reset_n = 1'b0;
        haddr   = 32'hC000_0000;
        htrans  = 2'b00;
        #1;
        chk("rst2_dsel", 64'(dsel), 64'(NSLV));
        reset_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("idle_unmapped_hready", 64'(hready), 64'(1));
            chk("idle_unmapped_hresp", 64'(hresp), 64'(0));
        end

        // Reset pulsed during ERR1 aborts the error response immediately.
        @(posedge clk);
        #1;
        htrans = 2'b10;
        @(posedge clk);
        #1;
        htrans = 2'b00;
        chk("err1_hready", 64'(hready), 64'(0));
        chk("err1_hresp", 64'(hresp), 64'(1));
        #2;
        reset_n = 1'b0;
        #1;
        chk("abort_hready", 64'(hready), 64'(1));
        chk("abort_hresp", 64'(hresp), 64'(0));
        chk("abort_dsel", 64'(dsel), 64'(NSLV));
        chk("abort_hrdata", 64'(hrdata), 64'(0));
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("post_abort_hready", 64'(hready), 64'(1));
            chk("post_abort_hresp", 64'(hresp), 64'(0));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
